// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path:
// opcode/funct constants, ALU op codes, mux-select codes, FSM state
// encodings, the control-word struct and the DECODE dispatch helper.
package cpu_defs_pkg;

  localparam int CPU_OP_W    = 6;
  localparam int CPU_ALUOP_W = 3;
  localparam int CPU_STATE_W = 4;

  // Primary opcodes (IR[31:26])
  localparam logic [CPU_OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [CPU_OP_W-1:0] OP_J     = 6'h02;
  localparam logic [CPU_OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [CPU_OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [CPU_OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [CPU_OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [CPU_OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [CPU_OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [CPU_OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [CPU_OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [CPU_OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [CPU_OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [CPU_OP_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [CPU_ALUOP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  // Register-file write address select
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALU operand selects
  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;
  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  // Next-PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  typedef enum logic [CPU_STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_MEM = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_EXEC_BR  = 4'd10,
    S_EXEC_J   = 4'd11,
    S_EXEC_JR  = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       aluout_we;
    logic       mdr_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_word_t;

  // State entered after DECODE; S_FETCH doubles as "undecodable".
  function automatic state_e dispatch_state(input logic [CPU_OP_W-1:0] opcode,
                                            input logic [CPU_OP_W-1:0] funct);
    state_e nxt;
    nxt = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:     nxt = S_EXEC_MEM;
      OP_ADDI, OP_XORI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:   nxt = S_EXEC_BR;
      OP_J, OP_JAL:     nxt = S_EXEC_J;
      OP_RTYPE: begin
        case (funct)
          FN_JR:                  nxt = S_EXEC_JR;
          FN_ADD, FN_SUB, FN_SLT: nxt = S_EXEC_R;
          default:                nxt = S_FETCH;
        endcase
      end
      default:          nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational control-word decoder: state + opcode + funct + zero
// -> every enable and mux select of the multicycle datapath.
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  state_e                state,
  input  logic [CPU_OP_W-1:0]   opcode,
  input  logic [CPU_OP_W-1:0]   funct,
  input  logic                  zero,
  output ctrl_word_t            cw
);

  // Moore decode per state; only EXEC_BR looks at zero/opcode for pc_we.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.ir_we     = 1'b1;
        cw.pc_we     = 1'b1;
        cw.alu_src_a = SRC_A_PC;
        cw.alu_src_b = SRC_B_FOUR;
        cw.alu_op    = ALU_ADD;
        cw.pc_src    = PC_SRC_ALU;
      end
      S_DECODE: begin
        if (dispatch_state(opcode, funct) == S_FETCH) begin
          cw.illegal = 1'b1;
        end else begin
          // Operand capture plus speculative branch target into ALUOut.
          cw.a_we      = 1'b1;
          cw.b_we      = 1'b1;
          cw.aluout_we = 1'b1;
          cw.alu_src_a = SRC_A_PC;
          cw.alu_src_b = SRC_B_IMM_SH2;
          cw.alu_op    = ALU_ADD;
        end
      end
      S_EXEC_MEM: begin
        cw.alu_src_a = SRC_A_REG;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_ADD;
        cw.aluout_we = 1'b1;
      end
      S_MEM_RD: cw.mdr_we = 1'b1;
      S_WB_MEM: begin
        cw.reg_we     = 1'b1;
        cw.reg_dst    = REG_DST_RT;
        cw.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: cw.mem_we = 1'b1;
      S_EXEC_R: begin
        cw.alu_src_a = SRC_A_REG;
        cw.alu_src_b = SRC_B_REG;
        cw.aluout_we = 1'b1;
        case (funct)
          FN_SUB:  cw.alu_op = ALU_SUB;
          FN_SLT:  cw.alu_op = ALU_SLT;
          default: cw.alu_op = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        cw.reg_we     = 1'b1;
        cw.reg_dst    = REG_DST_RD;
        cw.mem_to_reg = M2R_ALUOUT;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRC_A_REG;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        cw.aluout_we = 1'b1;
      end
      S_WB_I: begin
        cw.reg_we     = 1'b1;
        cw.reg_dst    = REG_DST_RT;
        cw.mem_to_reg = M2R_ALUOUT;
      end
      S_EXEC_BR: begin
        cw.alu_src_a = SRC_A_REG;
        cw.alu_src_b = SRC_B_REG;
        cw.alu_op    = ALU_SUB;
        cw.pc_src    = PC_SRC_ALUOUT;
        cw.pc_we     = ((opcode == OP_BEQ) &&  zero) ||
                       ((opcode == OP_BNE) && !zero);
      end
      S_EXEC_J: begin
        cw.pc_we  = 1'b1;
        cw.pc_src = PC_SRC_JUMP;
        if (opcode == OP_JAL) begin
          cw.reg_we     = 1'b1;
          cw.reg_dst    = REG_DST_RA;
          cw.mem_to_reg = M2R_PC;
        end
      end
      S_EXEC_JR: begin
        cw.pc_we  = 1'b1;
        cw.pc_src = PC_SRC_REG;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS-subset CPU. Holds the state
// register and next-state logic; the control word comes from ctrl_decode.
// Define CTRL_PERF_CNT_EN to add the 32-bit cycle_cnt/instr_cnt outputs.
module multicycle_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  output logic               pc_we,
  output logic               ir_we,
  output logic               a_we,
  output logic               b_we,
  output logic               aluout_we,
  output logic               mdr_we,
  output logic               mem_we,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt,
`endif
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  ctrl_word_t cw_raw, cw_out;

  ctrl_decode u_ctrl_decode (
    .state  (state_q),
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .cw     (cw_raw)
  );

  // Next-state sequencing; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = dispatch_state(opcode, funct);
      S_EXEC_MEM: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Reset squashes the whole control word so an abandoned instruction
  // cannot commit a write in the cycle reset rises.
  always_comb begin
    cw_out = cw_raw;
    if (reset) cw_out = '0;
  end

  assign pc_we      = cw_out.pc_we;
  assign ir_we      = cw_out.ir_we;
  assign a_we       = cw_out.a_we;
  assign b_we       = cw_out.b_we;
  assign aluout_we  = cw_out.aluout_we;
  assign mdr_we     = cw_out.mdr_we;
  assign mem_we     = cw_out.mem_we;
  assign reg_we     = cw_out.reg_we;
  assign reg_dst    = cw_out.reg_dst;
  assign mem_to_reg = cw_out.mem_to_reg;
  assign alu_src_a  = cw_out.alu_src_a;
  assign alu_src_b  = cw_out.alu_src_b;
  assign alu_op     = ALUOP_W'(cw_out.alu_op);
  assign pc_src     = cw_out.pc_src;
  assign illegal    = cw_out.illegal;
  assign state      = STATE_W'(state_q);

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  // FETCH always advances to DECODE outside reset, so FETCH marks a new instruction.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + ((state_q == S_FETCH) ? 32'd1 : 32'd0);
  end

  // Free-running wrap-around counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each issued instruction
// pushes its expected per-cycle state/control word, a negedge monitor pops
// and compares against the DUT.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        pc_we, ir_we, a_we, b_we, aluout_we, mdr_we, mem_we, reg_we;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic        alu_src_a, illegal;
  logic [2:0]  alu_op;
  logic [3:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .a_we       (a_we),
    .b_we       (b_we),
    .aluout_we  (aluout_we),
    .mdr_we     (mdr_we),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal    (illegal),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          st;
    logic [20:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  exp_t seq_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_instr = 0;

  logic [20:0] ctl_obs;
  assign ctl_obs = {pc_we, ir_we, a_we, b_we, aluout_we, mdr_we, mem_we, reg_we,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] cv(input logic pc, input logic ir, input logic a, input logic b,
                                     input logic ao, input logic mdr, input logic mw, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] m2r, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic [1:0] ps, input logic ill);
    return {pc, ir, a, b, ao, mdr, mw, rw, rd, m2r, sa, sb, op, ps, ill};
  endfunction

  function automatic void add(input string tag, input int st, input logic [20:0] c);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.ctl = c;
    seq_q.push_back(e);
  endfunction

  // Reference cycle sequence of one instruction from the ISA control table.
  function automatic void build_seq(input string nm, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z);
    logic legal, take, jal;
    logic [2:0] aop;
    seq_q.delete();
    case (op)
      6'h23, 6'h2B, 6'h08, 6'h0E, 6'h04, 6'h05, 6'h02, 6'h03: legal = 1'b1;
      6'h00: legal = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h2A) || (fn == 6'h08);
      default: legal = 1'b0;
    endcase
    add({nm, "/FETCH"}, 0, cv(1,1,0,0,0,0,0,0, 2'd0,2'd0,0,2'd1,3'd0,2'd0,0));
    if (!legal) begin
      add({nm, "/DECODE"}, 1, cv(0,0,0,0,0,0,0,0, 2'd0,2'd0,0,2'd0,3'd0,2'd0,1));
      return;
    end
    add({nm, "/DECODE"}, 1, cv(0,0,1,1,1,0,0,0, 2'd0,2'd0,0,2'd3,3'd0,2'd0,0));
    case (op)
      6'h23: begin
        add({nm, "/EXMEM"}, 2, cv(0,0,0,0,1,0,0,0, 2'd0,2'd0,1,2'd2,3'd0,2'd0,0));
        add({nm, "/MEMRD"}, 3, cv(0,0,0,0,0,1,0,0, 2'd0,2'd0,0,2'd0,3'd0,2'd0,0));
        add({nm, "/WBMEM"}, 4, cv(0,0,0,0,0,0,0,1, 2'd0,2'd1,0,2'd0,3'd0,2'd0,0));
      end
      6'h2B: begin
        add({nm, "/EXMEM"}, 2, cv(0,0,0,0,1,0,0,0, 2'd0,2'd0,1,2'd2,3'd0,2'd0,0));
        add({nm, "/MEMWR"}, 5, cv(0,0,0,0,0,0,1,0, 2'd0,2'd0,0,2'd0,3'd0,2'd0,0));
      end
      6'h00: begin
        if (fn == 6'h08) begin
          add({nm, "/EXJR"}, 12, cv(1,0,0,0,0,0,0,0, 2'd0,2'd0,0,2'd0,3'd0,2'd3,0));
        end else begin
          aop = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
          add({nm, "/EXR"}, 6, cv(0,0,0,0,1,0,0,0, 2'd0,2'd0,1,2'd0,aop,2'd0,0));
          add({nm, "/WBR"}, 7, cv(0,0,0,0,0,0,0,1, 2'd1,2'd0,0,2'd0,3'd0,2'd0,0));
        end
      end
      6'h08, 6'h0E: begin
        aop = (op == 6'h0E) ? 3'd2 : 3'd0;
        add({nm, "/EXI"}, 8, cv(0,0,0,0,1,0,0,0, 2'd0,2'd0,1,2'd2,aop,2'd0,0));
        add({nm, "/WBI"}, 9, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,0,2'd0,3'd0,2'd0,0));
      end
      6'h04, 6'h05: begin
        take = (op == 6'h04) ? z : !z;
        add({nm, "/EXBR"}, 10, cv(take,0,0,0,0,0,0,0, 2'd0,2'd0,1,2'd0,3'd1,2'd1,0));
      end
      default: begin
        jal = (op == 6'h03);
        add({nm, "/EXJ"}, 11, cv(1,0,0,0,0,0,0,jal, jal ? 2'd2 : 2'd0, jal ? 2'd2 : 2'd0,
                                 0,2'd0,3'd0,2'd2,0));
      end
    endcase
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, " state"}, 32'(state), 32'(e.st));
      check_eq({e.tag, " ctl"}, 32'(ctl_obs), 32'(e.ctl));
    end
  end

  // Wait (bounded) until the monitor consumed every expectation; returns 1 time unit after a posedge.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    #1;
  endtask

  // Issue one instruction; k>=0 raises reset after k of its cycles.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int k);
    exp_t r;
    opcode = op;
    funct  = fn;
    zero   = z;
    build_seq(nm, op, fn, z);
    for (int i = 0; i < seq_q.size() && (k < 0 || i < k); i++) sb_q.push_back(seq_q[i]);
    if (k != 0) exp_instr++;
    drain();
    if (k >= 0) begin
      reset = 1'b1;
      r.tag = {nm, "/rst0"}; r.st = seq_q[k].st; r.ctl = '0; sb_q.push_back(r);
      r.tag = {nm, "/rst1"}; r.st = 0;           r.ctl = '0; sb_q.push_back(r);
      drain();
`ifdef CTRL_PERF_CNT_EN
      check_eq({nm, " cycle_cnt rst"}, cycle_cnt, 32'd0);
      check_eq({nm, " instr_cnt rst"}, instr_cnt, 32'd0);
`endif
      exp_instr = 0;
      reset = 1'b0;
    end
  endtask

  initial begin
    exp_t r;
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    r.tag = "reset0"; r.st = 0; r.ctl = '0; sb_q.push_back(r);
    r.tag = "reset1";                         sb_q.push_back(r);
    drain();
    reset = 1'b0;

    run_instr("lw",       6'h23, 6'h00, 1'b0, -1);
    run_instr("sw",       6'h2B, 6'h00, 1'b0, -1);
    run_instr("beq_t",    6'h04, 6'h00, 1'b1, -1);
    run_instr("beq_nt",   6'h04, 6'h00, 1'b0, -1);
    run_instr("bne_z",    6'h05, 6'h00, 1'b1, -1);
    run_instr("bne_nz",   6'h05, 6'h00, 1'b0, -1);
    run_instr("slt",      6'h00, 6'h2A, 1'b0, -1);
    run_instr("add",      6'h00, 6'h20, 1'b0, -1);
    run_instr("sub",      6'h00, 6'h22, 1'b0, -1);
    run_instr("jr",       6'h00, 6'h08, 1'b0, -1);
    run_instr("addi",     6'h08, 6'h15, 1'b0, -1);
    run_instr("xori",     6'h0E, 6'h2A, 1'b1, -1);
    run_instr("j",        6'h02, 6'h00, 1'b0, -1);
    run_instr("jal",      6'h03, 6'h00, 1'b0, -1);
    run_instr("ill_op",   6'h3F, 6'h00, 1'b0, -1);
    run_instr("ill_fn",   6'h00, 6'h3F, 1'b0, -1);
    run_instr("lw_rst",   6'h23, 6'h00, 1'b0, 2);
    run_instr("addi",     6'h08, 6'h00, 1'b0, -1);
    run_instr("sw_rst",   6'h2B, 6'h00, 1'b0, 3);
    run_instr("lw",       6'h23, 6'h00, 1'b0, -1);
    run_instr("beq_t",    6'h04, 6'h00, 1'b1, -1);
`ifdef CTRL_PERF_CNT_EN
    check_eq("instr_cnt", instr_cnt, 32'(exp_instr));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
